mips32_pipe_fwd: RTL
====================

MIPS32_PIPE_FWD -- requirements
Module: mips32_pipe_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width (>=16).
REQ-002 SHALL have parameter IMEM_AW, default 10, instruction word-address width.
REQ-003 SHALL have parameter DMEM_AW, default 10, data word-address width.
REQ-004 SHALL have parameter FWD_EN, default 1; 1 = full forwarding, 0 = stall-only interlock.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 imem_addr  output  IMEM_AW  fetch word address (= PC).
REQ-008 imem_rdata  input  32  instruction at imem_addr, combinational, same cycle.
REQ-009 dmem_addr  output  DMEM_AW  data word address.
REQ-010 dmem_wdata  output  XLEN  store data.
REQ-011 dmem_we  output  1  store strobe; write occurs at the clk edge.
REQ-012 dmem_rdata  input  XLEN  load data at dmem_addr, combinational.
REQ-013 halted  output  1  HLT retired; core frozen.
REQ-014 retire_valid  output  1  one instruction left WB this cycle.
REQ-015 dbg_raddr  input  5  debug register select.
REQ-016 dbg_rdata  output  XLEN  Reg[dbg_raddr], combinational.

Function
REQ-017 SHALL decode opcode [31:26]: ADD 0, SUB 1, AND 2, OR 3, SLT 4, MUL 5, LW 8, SW 9, ADDI 10, SUBI 11, SLTI 12, BNEQZ 13, BEQZ 14, HLT 63; any other opcode SHALL execute as HLT.
REQ-018 SHALL use fields rs [25:21], rt [20:16], rd [15:11] and imm [15:0], with imm sign-extended to XLEN; RR instructions write rd; RM and LW write rt.
REQ-019 SHALL be a 5-stage IF/ID/EX/MEM/WB pipeline with one instruction per stage per clock; PC is a word address that increments by 1.
REQ-020 SHALL compute arithmetic modulo 2^XLEN; MUL keeps the low XLEN bits; SLT/SLTI compare signed and produce 1 or 0.
REQ-021 SHALL hardwire Reg[0] to zero: writes are discarded and r0 is never a forwarding source.
REQ-022 register file SHALL be write-first: a WB write is visible to an ID read in the same cycle.
REQ-023 FWD_EN=1: SHALL forward EX/MEM, then MEM/WB (youngest wins), into the EX operands, including the branch rs operand and SW store data.
REQ-024 FWD_EN=1: a load followed immediately by a consumer of its rt SHALL stall exactly 1 cycle, holding IF/ID and inserting a bubble into EX.
REQ-025 FWD_EN=0: ID SHALL stall while any valid instruction in EX or MEM writes a nonzero register that ID reads.
REQ-026 branches SHALL resolve in EX: BEQZ is taken if rs==0, BNEQZ if rs!=0; target = NPC + imm, truncated to IMEM_AW.
REQ-027 a taken branch SHALL flush IF/ID and ID/EX (2 bubbles) and load PC with the target on the next edge; a not-taken branch has no penalty.
REQ-028 flushed instructions SHALL produce no register write, no dmem_we and no halt.
REQ-029 when HLT is decoded in ID, fetch SHALL stop (PC frozen, bubbles into ID) and older instructions SHALL complete.
REQ-030 halted SHALL assert on the edge after HLT occupies WB and remain high; all state is then frozen until rst.
REQ-031 an HLT in a taken-branch shadow SHALL be flushed, and fetch SHALL resume at the target.
REQ-032 dmem_addr SHALL equal the low DMEM_AW bits of the EX/MEM ALU result; dmem_we SHALL be high only for a valid SW in MEM.
REQ-033 retire_valid SHALL be high for one cycle per non-bubble instruction in WB, including SW, branches and HLT.
REQ-034 stall plus a same-cycle taken branch: the flush SHALL take priority over the stall.

Reset
REQ-035 in the rst cycle SHALL set PC=0, all pipeline stages to bubbles, Reg[0..31]=0, halted=0, dmem_we=0 and retire_valid=0.
REQ-036 rst asserted mid-program SHALL abort all in-flight instructions, with no store in that cycle; the first fetch from address 0 occurs in the first cycle after rst drops.

Verification
REQ-037 Program ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT with FWD_EN=1 -> r3=30, zero stalls, halted 1 cycle after HLT reaches WB (4 retires).
REQ-038 Same program with FWD_EN=0 -> r3=30, exactly 2 stall cycles.
REQ-039 dmem[0]=7; LW r4,0(r0); ADD r5,r4,r4 -> exactly 1 stall cycle, r5=14.
REQ-040 ADDI r1,r0,0; BEQZ r1,+2; SW r1,5(r0); HLT; ADDI r6,r0,3; HLT -> dmem_we never high, r6=3, first HLT not retired.
REQ-041 ADDI r0,r0,5; ADD r7,r0,r0 -> r7=0, Reg[0]=0.
REQ-042 rst pulsed for 1 cycle mid-run of the REQ-037 program -> all registers 0, rerun gives r3=30.

Source files
------------

// File: rtl/mips32_pipe_fwd.sv
// Five-stage MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with EX-stage operand forwarding
// or, when FWD_EN is 0, a stall-only interlock. Branches resolve in EX.
module mips32_pipe_fwd #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned DMEM_AW = 10,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               halted,
  output logic               retire_valid,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata
);
  localparam logic [5:0] OpAdd = 6'd0, OpSub = 6'd1, OpAnd = 6'd2, OpOr = 6'd3, OpSlt = 6'd4;
  localparam logic [5:0] OpMul = 6'd5, OpLw = 6'd8, OpSw = 6'd9, OpAddi = 6'd10;
  localparam logic [5:0] OpSubi = 6'd11, OpSlti = 6'd12, OpBneqz = 6'd13, OpBeqz = 6'd14;
  localparam logic [5:0] OpHlt = 6'd63;
  localparam logic [IMEM_AW-1:0] PcOne = IMEM_AW'(1);

  logic [XLEN-1:0]    regs_q [32];
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic               halted_q, halted_d, fetch_off_q, fetch_off_d;
  logic               ifid_v_q, ifid_v_d;
  logic [31:0]        ifid_ir_q, ifid_ir_d;
  logic [IMEM_AW-1:0] ifid_npc_q, ifid_npc_d;
  logic               idex_v_q, idex_wr_q;
  logic [5:0]         idex_op_q;
  logic [4:0]         idex_rs_q, idex_rt_q, idex_dst_q;
  logic [XLEN-1:0]    idex_a_q, idex_b_q, idex_imm_q;
  logic [IMEM_AW-1:0] idex_npc_q;
  logic               exmem_v_q, exmem_wr_q;
  logic [5:0]         exmem_op_q;
  logic [4:0]         exmem_dst_q;
  logic [XLEN-1:0]    exmem_alu_q, exmem_b_q;
  logic               memwb_v_q, memwb_wr_q;
  logic [5:0]         memwb_op_q;
  logic [4:0]         memwb_dst_q;
  logic [XLEN-1:0]    memwb_res_q;

  // ID stage decode
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_dst;
  logic            id_rr, id_use_rs, id_use_rt, id_wr, id_hlt;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            wb_wr, hit_ex, hit_mem, stall;

  function automatic logic reads_reg(input logic use_rs, input logic use_rt,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] dst);
    return (dst != 5'd0) && ((use_rs && rs == dst) || (use_rt && rt == dst));
  endfunction

  always_comb begin
    case (ifid_ir_q[31:26])
      OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul, OpLw, OpSw, OpAddi, OpSubi, OpSlti, OpBneqz,
      OpBeqz, OpHlt: id_op = ifid_ir_q[31:26];
      default:       id_op = OpHlt;
    endcase
    id_rs     = ifid_ir_q[25:21];
    id_rt     = ifid_ir_q[20:16];
    id_rr     = id_op <= OpMul;
    id_use_rs = id_op != OpHlt;
    id_use_rt = id_rr || id_op == OpSw;
    id_wr     = id_rr || id_op == OpLw || (id_op inside {OpAddi, OpSubi, OpSlti});
    id_dst    = id_rr ? ifid_ir_q[15:11] : id_rt;
    id_hlt    = ifid_v_q && id_op == OpHlt;
    id_imm    = {{(XLEN-16){ifid_ir_q[15]}}, ifid_ir_q[15:0]};
    wb_wr     = memwb_v_q && memwb_wr_q && memwb_dst_q != 5'd0;
    // Write-first register file: WB result bypasses the array read in the same cycle
    id_a      = (wb_wr && memwb_dst_q == id_rs) ? memwb_res_q : regs_q[id_rs];
    id_b      = (wb_wr && memwb_dst_q == id_rt) ? memwb_res_q : regs_q[id_rt];
    hit_ex    = idex_v_q && idex_wr_q &&
                reads_reg(id_use_rs, id_use_rt, id_rs, id_rt, idex_dst_q);
    hit_mem   = exmem_v_q && exmem_wr_q &&
                reads_reg(id_use_rs, id_use_rt, id_rs, id_rt, exmem_dst_q);
    stall     = ifid_v_q && ((FWD_EN != 0) ? (hit_ex && idex_op_q == OpLw)
                                           : (hit_ex || hit_mem));
  end

  // EX stage: forwarding, ALU, branch resolution
  logic [XLEN-1:0]    ex_a, ex_b, ex_src2, ex_alu;
  logic               ex_taken;
  logic [IMEM_AW-1:0] ex_target;

  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
    if (FWD_EN != 0) begin
      if (exmem_v_q && exmem_wr_q && exmem_dst_q != 5'd0 && exmem_dst_q == idex_rs_q) begin
        ex_a = exmem_alu_q;
      end else if (wb_wr && memwb_dst_q == idex_rs_q) begin
        ex_a = memwb_res_q;
      end
      if (exmem_v_q && exmem_wr_q && exmem_dst_q != 5'd0 && exmem_dst_q == idex_rt_q) begin
        ex_b = exmem_alu_q;
      end else if (wb_wr && memwb_dst_q == idex_rt_q) begin
        ex_b = memwb_res_q;
      end
    end
    ex_src2 = (idex_op_q <= OpMul) ? ex_b : idex_imm_q;
    case (idex_op_q)
      OpAdd, OpAddi, OpLw, OpSw: ex_alu = ex_a + ex_src2;
      OpSub, OpSubi:             ex_alu = ex_a - ex_src2;
      OpAnd:                     ex_alu = ex_a & ex_src2;
      OpOr:                      ex_alu = ex_a | ex_src2;
      OpSlt, OpSlti:             ex_alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_src2)};
      OpMul:                     ex_alu = ex_a * ex_src2;
      default:                   ex_alu = '0;
    endcase
    ex_taken  = idex_v_q && ((idex_op_q == OpBeqz && ex_a == '0) ||
                             (idex_op_q == OpBneqz && ex_a != '0));
    ex_target = idex_npc_q + idex_imm_q[IMEM_AW-1:0];
  end

  // Fetch control: a taken branch overrides both the stall and the HLT fetch stop
  always_comb begin
    pc_d        = pc_q + PcOne;
    ifid_v_d    = 1'b1;
    ifid_ir_d   = imem_rdata;
    ifid_npc_d  = pc_q + PcOne;
    fetch_off_d = fetch_off_q || (id_hlt && !ex_taken);
    halted_d    = halted_q || (memwb_v_q && memwb_op_q == OpHlt);
    if (ex_taken) begin
      pc_d     = ex_target;
      ifid_v_d = 1'b0;
    end else if (stall) begin
      pc_d       = pc_q;
      ifid_v_d   = ifid_v_q;
      ifid_ir_d  = ifid_ir_q;
      ifid_npc_d = ifid_npc_q;
    end else if (fetch_off_q || id_hlt) begin
      pc_d     = pc_q;
      ifid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      halted_q    <= 1'b0;
      fetch_off_q <= 1'b0;
      ifid_v_q    <= 1'b0;
      ifid_ir_q   <= '0;
      ifid_npc_q  <= '0;
      idex_v_q    <= 1'b0;
      idex_wr_q   <= 1'b0;
      idex_op_q   <= '0;
      idex_rs_q   <= '0;
      idex_rt_q   <= '0;
      idex_dst_q  <= '0;
      idex_a_q    <= '0;
      idex_b_q    <= '0;
      idex_imm_q  <= '0;
      idex_npc_q  <= '0;
      exmem_v_q   <= 1'b0;
      exmem_wr_q  <= 1'b0;
      exmem_op_q  <= '0;
      exmem_dst_q <= '0;
      exmem_alu_q <= '0;
      exmem_b_q   <= '0;
      memwb_v_q   <= 1'b0;
      memwb_wr_q  <= 1'b0;
      memwb_op_q  <= '0;
      memwb_dst_q <= '0;
      memwb_res_q <= '0;
    end else if (!halted_q) begin
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      fetch_off_q <= fetch_off_d;
      ifid_v_q    <= ifid_v_d;
      ifid_ir_q   <= ifid_ir_d;
      ifid_npc_q  <= ifid_npc_d;
      idex_v_q    <= ifid_v_q && !stall && !ex_taken;
      idex_wr_q   <= ifid_v_q && !stall && !ex_taken && id_wr;
      idex_op_q   <= id_op;
      idex_rs_q   <= id_rs;
      idex_rt_q   <= id_rt;
      idex_dst_q  <= id_dst;
      idex_a_q    <= id_a;
      idex_b_q    <= id_b;
      idex_imm_q  <= id_imm;
      idex_npc_q  <= ifid_npc_q;
      exmem_v_q   <= idex_v_q;
      exmem_wr_q  <= idex_wr_q;
      exmem_op_q  <= idex_op_q;
      exmem_dst_q <= idex_dst_q;
      exmem_alu_q <= ex_alu;
      exmem_b_q   <= ex_b;
      memwb_v_q   <= exmem_v_q;
      memwb_wr_q  <= exmem_wr_q;
      memwb_op_q  <= exmem_op_q;
      memwb_dst_q <= exmem_dst_q;
      memwb_res_q <= (exmem_op_q == OpLw) ? dmem_rdata : exmem_alu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_wr && !halted_q) begin
      regs_q[memwb_dst_q] <= memwb_res_q;
    end
  end

  assign imem_addr    = pc_q;
  assign dmem_addr    = exmem_alu_q[DMEM_AW-1:0];
  assign dmem_wdata   = exmem_b_q;
  assign dmem_we      = exmem_v_q && exmem_op_q == OpSw && !halted_q && !rst;
  assign halted       = halted_q && !rst;
  assign retire_valid = memwb_v_q && !halted_q && !rst;
  assign dbg_rdata    = regs_q[dbg_raddr];
endmodule
